// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, field polynomial, GF(2^8) helpers and the
// control-FSM state type used by the round datapath stages.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8)
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by one of the small MixColumns constants (1, 2, 3, 9, b, d, e)
    // built from an xtime chain so synthesis sees only XOR trees.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            4'h1:    return x;
            4'h2:    return x2;
            4'h3:    return x2 ^ x;
            4'h9:    return x8 ^ x;
            4'hB:    return x8 ^ x2 ^ x;
            4'hD:    return x8 ^ x4 ^ x;
            4'hE:    return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns of one 32-bit column.
// Row 0 is the MSB byte; each output row uses the same coefficient set
// rotated by the row index.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    input  logic                 inv_en,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a_byte [4];
    logic [3:0] coef   [4];

    // Circulant row: {2,3,1,1} forward, {e,b,d,9} inverse
    assign coef[0] = inv_en ? 4'hE : 4'h2;
    assign coef[1] = inv_en ? 4'hB : 4'h3;
    assign coef[2] = inv_en ? 4'hD : 4'h1;
    assign coef[3] = inv_en ? 4'h9 : 4'h1;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_row
        assign a_byte[gi] = col_in[AES_COL_W-1-8*gi -: 8];
        assign col_out[AES_COL_W-1-8*gi -: 8] =
              gf_mul_const(a_byte[gi],         coef[0])
            ^ gf_mul_const(a_byte[(gi+1) % 4], coef[1])
            ^ gf_mul_const(a_byte[(gi+2) % 4], coef[2])
            ^ gf_mul_const(a_byte[(gi+3) % 4], coef[3]);
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Column-serial MixColumns / InvMixColumns stage with valid/ready handshake.
// A 128-bit state is latched on acceptance, COLS_PER_CYCLE columns are
// transformed in place per BUSY cycle (column 0 first), and the result is
// held in DONE until the consumer takes it. Bypass writes columns unchanged
// with identical timing so the final round keeps the same pipeline cadence.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int STATE_W        = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               inv_en,
    input  logic               bypass_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int NUM_COLS = 4;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_DONE = ST_DONE;

    // Counter wraps naturally: with 4 columns per cycle the step is 0 mod 4
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] CNT_LAST = 2'(NUM_COLS - COLS_PER_CYCLE);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
        if (STATE_W != AES_STATE_W) begin : g_bad_width
            $error("mix_columns_iter: STATE_W must be 128");
        end
    endgenerate

    logic [1:0]         state_reg, state_next;
    logic [1:0]         cnt_reg,   cnt_next;
    logic [STATE_W-1:0] work_reg,  work_next;
    logic               inv_reg,   inv_next;
    logic               byp_reg,   byp_next;

    logic accept;

    logic [AES_COL_W-1:0] col_arr   [NUM_COLS];
    logic [AES_COL_W-1:0] cols_next [NUM_COLS];

    logic [1:0]           lane_idx [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] lane_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] lane_mix [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] lane_out [COLS_PER_CYCLE];

    // Handshake: ready depends only on state and out_ready, and is held low in reset
    assign in_ready  = !rst && ((state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg == S_BUSY);
    assign out_data  = work_reg;

    genvar gi;

    // Word view of the working register, column 0 in the MSB word
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_unpack
        assign col_arr[gi] = work_reg[STATE_W-1-AES_COL_W*gi -: AES_COL_W];
    end

    // One transform lane per column handled this cycle; bypass muxed after the transform
    for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
        localparam logic [1:0] LANE_OFF = 2'(gi);

        assign lane_idx[gi] = cnt_reg + LANE_OFF;
        assign lane_in[gi]  = col_arr[lane_idx[gi]];

        mix_single_column u_mix (
            .col_in  (lane_in[gi]),
            .inv_en  (inv_reg),
            .col_out (lane_mix[gi])
        );

        assign lane_out[gi] = byp_reg ? lane_in[gi] : lane_mix[gi];
    end

    // Working columns after this cycle's lanes are written back
    always_comb begin
        cols_next = col_arr;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            cols_next[lane_idx[i]] = lane_out[i];
        end
    end

    // FSM next-state, counter, working register and latched mode bits
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
        inv_next   = inv_reg;
        byp_next   = byp_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_next = S_BUSY;
                    cnt_next   = 2'd0;
                    work_next  = in_data;
                    inv_next   = inv_en;
                    byp_next   = bypass_en;
                end else if ((state_reg == S_DONE) && out_ready) begin
                    state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                for (int i = 0; i < NUM_COLS; i++) begin
                    work_next[STATE_W-1-AES_COL_W*i -: AES_COL_W] = cols_next[i];
                end
                cnt_next = cnt_reg + CNT_STEP;
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any state in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 2'd0;
            work_reg  <= '0;
            inv_reg   <= 1'b0;
            byp_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            work_reg  <= work_next;
            inv_reg   <= inv_next;
            byp_reg   <= byp_next;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Testbench for mix_columns_iter: three instances (1, 2 and 4 columns per
// cycle) checked against a field-arithmetic reference model, a table of
// known vectors, and hand-written backpressure / mode-sampling / reset cases.
module tb_mix_columns_iter;

    logic         clk;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   inv_en;
    logic [2:0]   bypass_en;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [2:0]   busy;
    logic [127:0] in_data  [3];
    logic [127:0] out_data [3];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_dut
        mix_columns_iter #(
            .COLS_PER_CYCLE (1 << gi),
            .STATE_W        (128)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .inv_en    (inv_en[gi]),
            .bypass_en (bypass_en[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi]),
            .busy      (busy[gi])
        );
    end

    // ---------------- reference model ----------------
    // Generic GF(2^8) product by shift-and-add with reduction by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        int aa;
        int p;
        aa = a;
        p  = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) p = p ^ aa;
            aa = aa << 1;
            if (aa & 'h100) aa = aa ^ 'h11B;
        end
        return p[7:0];
    endfunction

    // Matrix product of every column with the (Inv)MixColumns circulant
    function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input logic byp);
        int coef_f [4] = '{2, 3, 1, 1};
        int coef_i [4] = '{14, 11, 13, 9};
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   acc;
        if (byp) return d;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) a[row] = d[127 - 8*(row + 4*c) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(a[(row + k) % 4], inv ? coef_i[k] : coef_f[k]);
                r[127 - 8*(row + 4*c) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Full transaction on instance k from IDLE; mode inputs toggle every
    // cycle after acceptance so the result must reflect the latched mode.
    task automatic xfer(input int k, input logic [127:0] d, input logic inv, input logic byp,
                        output logic [127:0] res, output int lat);
        in_data[k]   = d;
        inv_en[k]    = inv;
        bypass_en[k] = byp;
        in_valid[k]  = 1'b1;
        chk("in_ready_idle", {127'd0, in_ready[k]}, 128'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            inv_en[k]    = ~inv_en[k];
            bypass_en[k] = ~bypass_en[k];
            @(posedge clk); #1;
            lat++;
        end
        res = out_data[k];
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("out_valid_drop", {127'd0, out_valid[k]}, 128'd0);
        $display("txn cpc=%0d in=%h inv=%0b byp=%0b out=%h lat=%0d", 1 << k, d, inv, byp, res, lat);
    endtask

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [127:0] res;
        logic [127:0] d;
        logic [127:0] snap;
        logic         inv;
        logic         byp;
        int           lat;

        vt[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                  128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vt[1] = '{128'h9fdc589d_8e4da1bc_c6c6c6c6_01010101, 1'b1, 1'b0,
                  128'hf20a225c_db135345_c6c6c6c6_01010101};
        vt[2] = '{128'h01010101_c6c6c6c6_c6c6c6c6_01010101, 1'b1, 1'b0,
                  128'h01010101_c6c6c6c6_c6c6c6c6_01010101};
        vt[3] = '{128'h01234567_89abcdef_fedcba98_76543210, 1'b0, 1'b1,
                  128'h01234567_89abcdef_fedcba98_76543210};
        vt[4] = '{128'h01234567_89abcdef_fedcba98_76543210, 1'b1, 1'b1,
                  128'h01234567_89abcdef_fedcba98_76543210};

        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = '0;
        inv_en    = '0;
        bypass_en = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_data[k] = '0;

        // Reset state
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready",  {127'd0, in_ready[k]},  128'd0);
            chk("rst_out_valid", {127'd0, out_valid[k]}, 128'd0);
            chk("rst_busy",      {127'd0, busy[k]},      128'd0);
            chk("rst_out_data",  out_data[k],            128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {125'd0, in_ready}, 128'd7);

        // Known vectors on the single-column instance
        for (int i = 0; i < 5; i++) begin
            xfer(0, vt[i].din, vt[i].inv, vt[i].byp, res, lat);
            chk("vec_data", res, vt[i].exp);
            chk("vec_latency", 128'(lat), 128'd4);
        end

        // Random states, all three column widths
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                d   = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom);
                byp = (i % 4 == 0) ? 1'b1 : 1'b0;
                xfer(k, d, inv, byp, res, lat);
                chk("rand_data", res, model(d, inv, byp));
                chk("rand_latency", 128'(lat), 128'(4 >> k));
            end
        end

        // Backpressure in DONE, then back-to-back acceptance
        d = {$urandom, $urandom, $urandom, $urandom};
        in_data[0] = d; inv_en[0] = 1'b0; bypass_en[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", 128'(lat), 128'd4);
        snap = out_data[0];
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_stable",    out_data[0], snap);
            chk("bp_in_ready",  {127'd0, in_ready[0]},  128'd0);
            chk("bp_out_valid", {127'd0, out_valid[0]}, 128'd1);
        end
        chk("bp_data", out_data[0], model(d, 1'b0, 1'b0));
        $display("txn backpressure held out=%h", out_data[0]);
        d = {$urandom, $urandom, $urandom, $urandom};
        in_data[0] = d; inv_en[0] = 1'b1; bypass_en[0] = 1'b0;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        chk("b2b_in_ready", {127'd0, in_ready[0]}, 128'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        chk("b2b_out_valid_low", {127'd0, out_valid[0]}, 128'd0);
        chk("b2b_busy", {127'd0, busy[0]}, 128'd1);
        lat = 0;
        while (!out_valid[0] && lat < 20) begin
            inv_en[0] = ~inv_en[0]; bypass_en[0] = ~bypass_en[0];
            @(posedge clk); #1; lat++;
        end
        chk("b2b_latency", 128'(lat), 128'd4);
        chk("b2b_data", out_data[0], model(d, 1'b1, 1'b0));
        $display("txn back-to-back in=%h out=%h lat=%0d", d, out_data[0], lat);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;

        // Asynchronous reset two cycles into BUSY
        in_data[0] = {$urandom, $urandom, $urandom, $urandom};
        inv_en[0] = 1'b0; bypass_en[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_busy", {127'd0, busy[0]}, 128'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {127'd0, out_valid[0]}, 128'd0);
        chk("arst_out_data",  out_data[0],            128'd0);
        chk("arst_busy",      {127'd0, busy[0]},      128'd0);
        chk("arst_in_ready",  {127'd0, in_ready[0]},  128'd0);
        $display("txn async reset mid-busy");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("arst_release_ready", {127'd0, in_ready[0]}, 128'd1);
        d = {$urandom, $urandom, $urandom, $urandom};
        xfer(0, d, 1'b0, 1'b0, res, lat);
        chk("arst_after_data", res, model(d, 1'b0, 1'b0));
        chk("arst_after_latency", 128'(lat), 128'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
